// File: rtl/key_set_controller_if.sv
// Set/adjust key bundle: raw keys in, field select and strobes out.
// master = key controller, slave = field demux side.
interface key_set_controller_if;
  logic       key_mode_n;
  logic       key_adj_n;
  logic [1:0] set;
  logic       adj_pulse_n;
  logic       mode_pulse;
  logic       editing;

  modport master (
    input  key_mode_n,
    input  key_adj_n,
    output set,
    output adj_pulse_n,
    output mode_pulse,
    output editing
  );

  modport slave (
    output key_mode_n,
    output key_adj_n,
    input  set,
    input  adj_pulse_n,
    input  mode_pulse,
    input  editing
  );
endinterface

// File: rtl/key_set_controller.sv
// MODE/ADJ key front-end: sync, debounce, field select,
// adjust strobe with auto-repeat and edit timeout.
module key_set_controller #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int HOLD_CYCLES     = 500000,
  parameter int REPEAT_CYCLES   = 100000,
  parameter int TIMEOUT_CYCLES  = 50000000
) (
  input logic                  clk,
  input logic                  rst_n,
  key_set_controller_if.master ks
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ?
    $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int AMAX = (HOLD_CYCLES > REPEAT_CYCLES) ?
    HOLD_CYCLES : REPEAT_CYCLES;
  localparam int AW = (AMAX > 1) ? $clog2(AMAX) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ?
    $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW-1:0] HLD_MAX = AW'(HOLD_CYCLES - 1);
  localparam logic [AW-1:0] REP_MAX = AW'(REPEAT_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES - 1);
  localparam bit            TO_EN   = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    REPEAT
  } adj_st_e;

  // index 0 = MODE, 1 = ADJ
  logic [1:0]    s1, s2, lvl, lvl_q;
  logic [DW-1:0] dcnt [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 2'b11;
      s2    <= 2'b11;
      lvl   <= 2'b11;
      lvl_q <= 2'b11;
      for (int i = 0; i < 2; i++) dcnt[i] <= '0;
    end else begin
      s1    <= {ks.key_adj_n, ks.key_mode_n};
      s2    <= s1;
      lvl_q <= lvl;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == lvl[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DB_MAX) begin
          lvl[i]  <= s2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
      end
    end
  end

  logic [1:0] ev;
  logic       mode_ev, adj_ev, adj_up;
  assign ev      = lvl_q & ~lvl;
  assign mode_ev = ev[0];
  assign adj_ev  = ev[1];
  assign adj_up  = lvl[1];

  adj_st_e       st, st_d;
  logic [AW-1:0] at, at_d;
  logic [TW-1:0] tcnt, tcnt_d;
  logic [1:0]    set_q, set_d;
  logic          editing_q, mode_pulse_q, adj_pulse_n_q;
  logic          fire, tmo_fire, run;

  assign run = (set_q == 2'd3);

  // a press on the timeout cycle keeps the user in edit mode
  assign tmo_fire = TO_EN && !run && (tcnt == TO_MAX) && !(|ev);

  always_comb begin
    set_d  = set_q;
    tcnt_d = tcnt + 1'b1;
    if (mode_ev)       set_d = set_q + 2'd1;
    else if (tmo_fire) set_d = 2'd3;
    if ((|ev) || run || tmo_fire) tcnt_d = '0;
  end

  always_comb begin
    st_d = st;
    at_d = at;
    fire = 1'b0;
    if (mode_ev || tmo_fire) begin
      st_d = IDLE;
      at_d = '0;
    end else begin
      unique case (st)
        IDLE: begin
          if (adj_ev && !run) begin
            fire = 1'b1;
            st_d = HELD;
            at_d = '0;
          end
        end
        HELD: begin
          if (adj_up) begin
            st_d = IDLE;
          end else if (at == HLD_MAX) begin
            fire = 1'b1;
            st_d = REPEAT;
            at_d = '0;
          end else begin
            at_d = at + 1'b1;
          end
        end
        REPEAT: begin
          if (adj_up) begin
            st_d = IDLE;
          end else if (at == REP_MAX) begin
            fire = 1'b1;
            at_d = '0;
          end else begin
            at_d = at + 1'b1;
          end
        end
        default: st_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st            <= IDLE;
      at            <= '0;
      tcnt          <= '0;
      set_q         <= 2'd3;
      editing_q     <= 1'b0;
      mode_pulse_q  <= 1'b0;
      adj_pulse_n_q <= 1'b1;
    end else begin
      st            <= st_d;
      at            <= at_d;
      tcnt          <= tcnt_d;
      set_q         <= set_d;
      editing_q     <= (set_d != 2'd3);
      mode_pulse_q  <= mode_ev;
      adj_pulse_n_q <= ~fire;
    end
  end

  assign ks.set         = set_q;
  assign ks.editing     = editing_q;
  assign ks.mode_pulse  = mode_pulse_q;
  assign ks.adj_pulse_n = adj_pulse_n_q;

endmodule

// File: tb/tb_key_set_controller.sv
// Directed bench for key_set_controller with short
// debounce/hold/repeat/timeout parameters.
module tb_key_set_controller;

  localparam int DB   = 4;
  localparam int HOLD = 10;
  localparam int REP  = 5;
  localparam int TMO  = 100;
  localparam int LAT  = DB + 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  key_set_controller_if ks ();

  key_set_controller #(
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES    (HOLD),
    .REPEAT_CYCLES  (REP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ks   (ks)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int adj_q[$];
  int mode_q[$];
  logic prev_adj_low = 1'b0;
  logic prev_mode_hi = 1'b0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // record strobe timestamps, strobes must be single-clock
  always @(negedge clk) begin
    if (!ks.adj_pulse_n) begin
      adj_q.push_back(cyc);
      chk("adj_single", 32'(prev_adj_low), 0);
    end
    if (ks.mode_pulse) begin
      mode_q.push_back(cyc);
      chk("mode_single", 32'(prev_mode_hi), 0);
    end
    prev_adj_low = !ks.adj_pulse_n;
    prev_mode_hi = ks.mode_pulse;
  end

  task automatic press_key(input bit m, input bit a,
                           input int hold, input int tail,
                           output int t0);
    @(posedge clk); #1;
    t0 = cyc;
    if (m) ks.key_mode_n = 1'b0;
    if (a) ks.key_adj_n  = 1'b0;
    repeat (hold) @(posedge clk);
    #1;
    ks.key_mode_n = 1'b1;
    ks.key_adj_n  = 1'b1;
    repeat (tail) @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  typedef struct {
    bit         m;
    bit         a;
    int         hold;
    int         n_mode;
    int         n_adj;
    logic [1:0] set;
    logic       ed;
    bit         rep;
  } vec_t;

  vec_t v[13];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t0;
    ks.key_mode_n = 1'b1;
    ks.key_adj_n  = 1'b1;

    v[0]  = '{1, 0, 10, 1, 0, 2'd0, 1'b1, 0};
    v[1]  = '{1, 0, 10, 1, 0, 2'd1, 1'b1, 0};
    v[2]  = '{1, 0, 10, 1, 0, 2'd2, 1'b1, 0};
    v[3]  = '{1, 0, 10, 1, 0, 2'd3, 1'b0, 0};
    v[4]  = '{1, 0,  3, 0, 0, 2'd3, 1'b0, 0};
    v[5]  = '{0, 1, 40, 0, 0, 2'd3, 1'b0, 0};
    v[6]  = '{1, 0, 10, 1, 0, 2'd0, 1'b1, 0};
    v[7]  = '{1, 0, 10, 1, 0, 2'd1, 1'b1, 0};
    v[8]  = '{0, 1, 30, 0, 5, 2'd1, 1'b1, 1};
    v[9]  = '{0, 1,  3, 0, 0, 2'd1, 1'b1, 0};
    v[10] = '{1, 0, 10, 1, 0, 2'd2, 1'b1, 0};
    v[11] = '{1, 0, 10, 1, 0, 2'd3, 1'b0, 0};
    v[12] = '{1, 0, 10, 1, 0, 2'd0, 1'b1, 0};

    // async reset, checked before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_set", 32'(ks.set), 3);
    chk("rst_adj", 32'(ks.adj_pulse_n), 1);
    chk("rst_mode", 32'(ks.mode_pulse), 0);
    chk("rst_edit", 32'(ks.editing), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // MODE bounce: 3 low, 1 high, 3 low
    mode_q.delete();
    @(posedge clk); #1;
    ks.key_mode_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 ks.key_mode_n = 1'b1;
    @(posedge clk);
    #1 ks.key_mode_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 ks.key_mode_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("bounce_mode", mode_q.size(), 0);
    chk("bounce_set", 32'(ks.set), 3);

    for (int i = 0; i < 13; i++) begin
      adj_q.delete();
      mode_q.delete();
      press_key(v[i].m, v[i].a, v[i].hold, 12, t0);
      chk($sformatf("v%0d_nmode", i), mode_q.size(), v[i].n_mode);
      chk($sformatf("v%0d_nadj", i), adj_q.size(), v[i].n_adj);
      chk($sformatf("v%0d_set", i), 32'(ks.set), 32'(v[i].set));
      chk($sformatf("v%0d_edit", i), 32'(ks.editing), 32'(v[i].ed));
      if (v[i].n_mode > 0 && mode_q.size() > 0)
        chk($sformatf("v%0d_mlat", i), mode_q[0] - t0, LAT);
      if (v[i].n_adj > 0 && adj_q.size() > 0)
        chk($sformatf("v%0d_alat", i), adj_q[0] - t0, LAT);
      if (v[i].rep && adj_q.size() == 5)
        for (int k = 1; k < 5; k++)
          chk($sformatf("v%0d_gap%0d", i, k),
              adj_q[k] - adj_q[k-1], (k == 1) ? HOLD : REP);
    end

    // MODE during REPEAT cancels the auto-repeat
    adj_q.delete();
    mode_q.delete();
    @(posedge clk); #1;
    t0 = cyc;
    ks.key_adj_n = 1'b0;
    repeat (25) @(posedge clk);
    #1 ks.key_mode_n = 1'b0;
    repeat (10) @(posedge clk);
    #1 ks.key_mode_n = 1'b1;
    repeat (15) @(posedge clk);
    #1 ks.key_adj_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("mc_nadj", adj_q.size(), 4);
    if (adj_q.size() == 4)
      chk("mc_last_adj", adj_q[3] - t0, LAT + HOLD + 2 * REP);
    chk("mc_nmode", mode_q.size(), 1);
    if (mode_q.size() == 1)
      chk("mc_mlat", mode_q[0] - t0, 25 + LAT);
    chk("mc_set", 32'(ks.set), 1);

    adj_q.delete();
    press_key(0, 1, 8, 12, t0);
    chk("repress_nadj", adj_q.size(), 1);
    if (adj_q.size() == 1)
      chk("repress_lat", adj_q[0] - t0, LAT);

    // simultaneous MODE/ADJ: MODE wins
    adj_q.delete();
    mode_q.delete();
    press_key(1, 1, 10, 12, t0);
    chk("sim_nadj", adj_q.size(), 0);
    chk("sim_nmode", mode_q.size(), 1);
    chk("sim_set", 32'(ks.set), 2);

    // timeout: set became 2 at t0+LAT
    wait_cyc(t0 + LAT + TMO - 1);
    chk("tmo_before", 32'(ks.set), 2);
    wait_cyc(t0 + LAT + TMO);
    chk("tmo_set", 32'(ks.set), 3);
    chk("tmo_edit", 32'(ks.editing), 0);

    // reset while an adjust strobe is active
    press_key(1, 0, 10, 12, t0);
    chk("pre_rst_set", 32'(ks.set), 0);
    @(posedge clk); #1;
    t0 = cyc;
    ks.key_adj_n = 1'b0;
    wait_cyc(t0 + LAT + HOLD + REP);
    chk("pre_rst_adj", 32'(ks.adj_pulse_n), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_set", 32'(ks.set), 3);
    chk("mid_rst_adj", 32'(ks.adj_pulse_n), 1);
    chk("mid_rst_edit", 32'(ks.editing), 0);
    @(negedge clk);
    rst_n = 1'b1;
    adj_q.delete();
    mode_q.delete();
    repeat (30) @(posedge clk);
    #1;
    chk("post_rst_nadj", adj_q.size(), 0);
    chk("post_rst_nmode", mode_q.size(), 0);
    chk("post_rst_set", 32'(ks.set), 3);
    ks.key_adj_n = 1'b1;
    repeat (12) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
